instr_fetch: RTL
================

# instr_fetch

Instruction fetch unit for the single-cycle RISC-V core: the initiator side of the instruction-memory read port. It owns the program counter, presents a word address to the instruction memory every cycle, captures the combinational read data into a 2-entry fetch buffer, and hands `{pc, instr}` pairs to decode over a valid/ready handshake. Branch and jump resolution redirects the PC and flushes the buffer.

## Interface
Parameters:
- `N`, 32, data/address width.
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  N  byte address to instruction memory; always equals the PC register, bits [1:0] = 0.
- `imem_rdata`  in  N  instruction word, valid combinationally in the same cycle as `imem_addr`.
- `redirect_valid`  in  1  taken branch/jump this cycle.
- `redirect_pc`  in  N  redirect target.
- `out_valid`  out  1  buffer head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  N  head instruction; 0 when empty.
- `out_pc`  out  N  PC of head instruction; 0 when empty.
- `fetch_fault`  out  1  present only with `IFETCH_MISALIGN_TRAP_EN`.

## Operation
- State: `pc` (N bits), buffer `entry[0..1]` of `{pc, instr}`, `count` (0..2), read pointer, write pointer (1 bit each, wrap modulo 2).
- Pop: `pop = out_valid & out_ready`. Head advances, `count` decrements.
- Fetch: `fetch = ~redirect_valid & (count < 2 | pop)` (and not faulted, see Configuration). On fetch: `entry[wr] <= {pc, imem_rdata}`, `pc <= pc + 4` (modulo 2^N, wraps 0xFFFF_FFFC -> 0).
- Simultaneous fetch and pop at `count == 2` or `count == 1`: `count` unchanged.
- Redirect has priority over everything. On `redirect_valid`: `count <= 0`, both pointers reset to 0, `pc <= {redirect_pc[N-1:2], 2'b00}`, no fetch that cycle. A pop in the same cycle still counts as accepted by decode; all other buffered entries are discarded.
- `out_valid = (count != 0)`; `out_instr`/`out_pc` come from `entry[rd]` when valid, else 0.
- Reset: `pc = RESET_PC`, `count = 0`, pointers 0, `out_valid = 0`, `out_instr = 0`, `out_pc = 0`, `imem_addr = RESET_PC`, `fetch_fault = 0`. Reset mid-operation discards all buffered entries and overrides a concurrent redirect.

## Timing
- Fetch latency: address presented in cycle t; entry visible on `out_*` in cycle t+1.
- After `rst` deasserts at edge e: cycle e fetches `RESET_PC`; `out_valid = 1` from cycle e+1.
- Redirect asserted in cycle t: `out_valid = 0` in t+1 while `imem_addr = target`; target instruction appears on `out_*` in t+2.
- Steady state with `out_ready` held high: one instruction per cycle, `out_pc` increments by 4 each cycle.
- Decode stall (`out_ready = 0`): buffer fills in 2 cycles, then `pc` and `imem_addr` hold. On release, throughput resumes at 1/cycle with no bubble.

## Configuration
- `IFETCH_MISALIGN_TRAP_EN` defined: `fetch_fault` port exists. A redirect with `redirect_pc[1:0] != 0` flushes the buffer, sets sticky `fetch_fault = 1`, and blocks all fetches (`out_valid` stays 0). The fault clears only on reset or on a later redirect with an aligned target, which resumes fetching normally.
- Not defined: no `fetch_fault` port; redirect bits [1:0] are silently forced to 0.

## Test plan
- Reset then `out_ready = 1`, memory words 0 = 32'hFFC4A303 and 1 = 32'h00832383 -> cycle 1 `out_pc = 0`, `out_instr = 32'hFFC4A303`; cycle 2 `out_pc = 4`, `out_instr = 32'h00832383`.
- Hold `out_ready = 0` for 5 cycles after reset -> `count` saturates at 2 and `imem_addr` holds 32'h8; release -> `out_pc` 0, 4, 8 on consecutive cycles with no bubble.
- Assert redirect to 32'h40 while the buffer is full and a pop occurs -> popped entry counts as accepted, remainder is flushed, next cycle `out_valid = 0`, following cycle `out_pc = 32'h40`.
- Redirect to 32'hFFFF_FFFC, run 2 cycles -> `out_pc` 32'hFFFF_FFFC then 32'h0 (wrap).
- Redirect to 32'h42 -> without the macro, `out_pc = 32'h40`; with the macro, `fetch_fault = 1` and `out_valid` stays 0; a later redirect to 32'h80 clears the fault and `out_pc = 32'h80`.
- Assert `rst` together with `redirect_valid` mid-stream -> reset wins: `out_valid = 0` and `imem_addr = RESET_PC` next cycle.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, instruction-memory read initiator, 2-entry fetch buffer.
// Optional IFETCH_MISALIGN_TRAP_EN adds a sticky fetch_fault on misaligned redirects.
module instr_fetch #(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_rdata,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_instr,
    output logic [N-1:0] out_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic         fetch_fault
`endif
);

    logic [N-1:0]        pc_q, pc_d;
    logic [1:0][N-1:0]   ent_pc_q, ent_pc_d;
    logic [1:0][N-1:0]   ent_instr_q, ent_instr_d;
    logic [1:0]          count_q, count_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                pop;
    logic                fetch;
    logic                blocked;
    logic [N-1:0]        target;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic                fault_q, fault_d;
    assign blocked     = fault_q;
    assign fetch_fault = fault_q;
`else
    assign blocked     = 1'b0;
`endif

    assign imem_addr = pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_instr = out_valid ? ent_instr_q[rd_q] : '0;
    assign out_pc    = out_valid ? ent_pc_q[rd_q] : '0;
    assign target    = redirect_pc & ~N'(3);
    assign pop       = out_valid & out_ready;
    assign fetch     = ~redirect_valid & ~blocked & ((count_q != 2'd2) | pop);

    // Next-state: redirect flushes and retargets, otherwise fetch and/or pop.
    always_comb begin
        pc_d        = pc_q;
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;
        count_d     = count_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
        fault_d     = fault_q;
`endif
        if (redirect_valid) begin
            count_d = 2'd0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            pc_d    = target;
`ifdef IFETCH_MISALIGN_TRAP_EN
            fault_d = |redirect_pc[1:0];
`endif
        end else begin
            if (fetch) begin
                ent_pc_d[wr_q]    = pc_q;
                ent_instr_d[wr_q] = imem_rdata;
                wr_d              = ~wr_q;
                pc_d              = pc_q + N'(4);
            end
            if (pop) begin
                rd_d = ~rd_q;
            end
            count_d = count_q + {1'b0, fetch} - {1'b0, pop};
        end
    end

    // State register with synchronous reset overriding any redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ent_pc_q    <= '0;
            ent_instr_q <= '0;
            count_q     <= 2'd0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            pc_q        <= pc_d;
            ent_pc_q    <= ent_pc_d;
            ent_instr_q <= ent_instr_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            fault_q     <= fault_d;
`endif
        end
    end

endmodule
